// File: rtl/myproject_mul_pipe_pkg.sv
// Shared constants and helpers for the pipelined multiplier:
// stage limit, full product width and clamp bounds.
package myproject_mul_pipe_pkg;

  localparam int MAX_STAGE = 8;

  typedef struct packed {
    logic [63:0] maxVal;
    logic [63:0] minVal;
  } sat_bounds_t;

  function automatic int prodWidth(input int w0, input int w1);
    return w0 + w1;
  endfunction

  // Only the low w bits of each bound are meaningful.
  function automatic sat_bounds_t satBounds(input int w, input bit isSigned);
    sat_bounds_t b;
    if (isSigned) begin
      b.maxVal = (64'd1 << (w - 1)) - 64'd1;
      b.minVal = 64'd1 << (w - 1);
    end else begin
      b.maxVal = (64'd1 << w) - 64'd1;
      b.minVal = 64'd0;
    end
    return b;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_sat.sv
// Final-stage result shaping: fits a full-width product into the output
// width by wrapping or clamping, and flags any lost information.
module myproject_mul_pipe_sat
  import myproject_mul_pipe_pkg::*;
#(
  parameter int P_WIDTH    = 12,
  parameter bit P_SIGNED   = 1'b1,
  parameter int DOUT_WIDTH = 12,
  parameter bit SATURATE   = 1'b0
) (
  input  logic [P_WIDTH-1:0]    i_prod,
  output logic [DOUT_WIDTH-1:0] o_dout,
  output logic                  o_ovf
);

  generate
    if (DOUT_WIDTH > P_WIDTH) begin : g_widen
      logic w_fill;
      assign w_fill = P_SIGNED ? i_prod[P_WIDTH-1] : 1'b0;
      assign o_dout = {{(DOUT_WIDTH - P_WIDTH){w_fill}}, i_prod};
      assign o_ovf  = 1'b0;
    end else if (DOUT_WIDTH == P_WIDTH) begin : g_exact
      assign o_dout = i_prod;
      assign o_ovf  = 1'b0;
    end else begin : g_narrow
      logic [DOUT_WIDTH-1:0] w_trunc;
      logic                  w_fill;
      logic [P_WIDTH-1:0]    w_reext;
      logic                  w_lost;

      // Information is lost exactly when re-extending the kept bits fails
      // to reproduce the full product.
      assign w_trunc = i_prod[DOUT_WIDTH-1:0];
      assign w_fill  = P_SIGNED ? w_trunc[DOUT_WIDTH-1] : 1'b0;
      assign w_reext = {{(P_WIDTH - DOUT_WIDTH){w_fill}}, w_trunc};
      assign w_lost  = (w_reext != i_prod);
      assign o_ovf   = w_lost;

      if (SATURATE) begin : g_clamp
        localparam sat_bounds_t BOUNDS = satBounds(DOUT_WIDTH, P_SIGNED);
        always_comb begin
          o_dout = w_trunc;
          if (w_lost) begin
            o_dout = (P_SIGNED && i_prod[P_WIDTH-1]) ? BOUNDS.minVal[DOUT_WIDTH-1:0]
                                                      : BOUNDS.maxVal[DOUT_WIDTH-1:0];
          end
        end
      end else begin : g_wrap
        assign o_dout = w_trunc;
      end
    end
  endgenerate

endmodule

// File: rtl/myproject_mul_pipe.sv
// Pipelined multiplier with valid/ready handshake and a single global stall;
// multiply registers first, wrap/clamp and overflow in the last stage.
module myproject_mul_pipe
  import myproject_mul_pipe_pkg::*;
#(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 3,
  parameter int din1_WIDTH  = 9,
  parameter int dout_WIDTH  = 12,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 1,
  parameter int SATURATE    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int P        = prodWidth(din0_WIDTH, din1_WIDTH);
  localparam bit P_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

  generate
    if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE) begin : g_badStage
      $error("myproject_mul_pipe: NUM_STAGE out of range");
    end
  endgenerate

  logic                  w_advance;
  logic                  w_s0;
  logic                  w_s1;
  logic [P-1:0]          w_a;
  logic [P-1:0]          w_b;
  logic [P-1:0]          w_prod;
  logic [P-1:0]          w_lastProd;
  logic                  w_lastValid;
  logic [dout_WIDTH-1:0] w_satDout;
  logic                  w_satOvf;
  logic                  r_outValid;
  logic [dout_WIDTH-1:0] r_dout;
  logic                  r_ovf;

  assign w_advance = ce & ~reset & (~r_outValid | out_ready);
  assign in_ready  = w_advance;

  // Low P bits of the product of the P-bit extended operands are exact.
  assign w_s0   = (DIN0_SIGNED != 0) & din0[din0_WIDTH-1];
  assign w_s1   = (DIN1_SIGNED != 0) & din1[din1_WIDTH-1];
  assign w_a    = {{din1_WIDTH{w_s0}}, din0};
  assign w_b    = {{din0_WIDTH{w_s1}}, din1};
  assign w_prod = w_a * w_b;

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign w_lastProd  = w_prod;
      assign w_lastValid = in_valid;
      assign busy        = r_outValid;
    end else begin : g_multi
      logic [P-1:0]           r_prod [NUM_STAGE-1];
      logic [NUM_STAGE-2:0]   r_pv;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pv <= '0;
        end else if (w_advance) begin
          r_pv[0] <= in_valid;
          for (int s = 1; s < NUM_STAGE - 1; s++) begin
            r_pv[s] <= r_pv[s-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_advance) begin
          r_prod[0] <= w_prod;
          for (int s = 1; s < NUM_STAGE - 1; s++) begin
            r_prod[s] <= r_prod[s-1];
          end
        end
      end

      assign w_lastProd  = r_prod[NUM_STAGE-2];
      assign w_lastValid = r_pv[NUM_STAGE-2];
      assign busy        = r_outValid | (|r_pv);
    end
  endgenerate

  myproject_mul_pipe_sat #(
    .P_WIDTH    (P),
    .P_SIGNED   (P_SIGNED),
    .DOUT_WIDTH (dout_WIDTH),
    .SATURATE   (SATURATE != 0)
  ) u_sat (
    .i_prod (w_lastProd),
    .o_dout (w_satDout),
    .o_ovf  (w_satOvf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid <= 1'b0;
      r_dout     <= '0;
      r_ovf      <= 1'b0;
    end else if (w_advance) begin
      r_outValid <= w_lastValid;
      r_ovf      <= w_lastValid & w_satOvf;
      if (w_lastValid) begin
        r_dout <= w_satDout;
      end
    end
  end

  assign out_valid = r_outValid;
  assign dout      = r_dout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_myproject_mul_pipe.sv
// Self-checking bench: five configurations of the multiplier share one input
// bus, each with its own scoreboard queue fed from an independent model.
module tb_myproject_mul_pipe;

  localparam int NDUT = 5;
  // 0: defaults  1: 8-bit unsigned wrap  2: 8-bit unsigned sat  3: NS=1  4: NS=8
  localparam int CFG_NS  [NDUT] = '{2, 2, 2, 1, 8};
  localparam int CFG_DW  [NDUT] = '{12, 8, 8, 12, 12};
  localparam int CFG_D1S [NDUT] = '{1, 0, 0, 1, 1};
  localparam int CFG_SAT [NDUT] = '{0, 0, 1, 0, 0};

  typedef struct packed {
    logic [11:0] dout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [2:0]  d0;
    logic [8:0]  d1;
    logic [11:0] exp12;
    logic [7:0]  exp8w;
    logic        ovf8w;
    logic [7:0]  exp8s;
    logic        ovf8s;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;
  logic inValid = 1'b0;
  logic outReady = 1'b0;
  logic [2:0] din0 = '0;
  logic [8:0] din1 = '0;

  wire [NDUT-1:0] inReady;
  wire [NDUT-1:0] outValid;
  wire [NDUT-1:0] ovfV;
  wire [NDUT-1:0] busyV;
  wire [11:0] dout0;
  wire [7:0]  dout1;
  wire [7:0]  dout2;
  wire [11:0] dout3;
  wire [11:0] dout4;
  wire [11:0] doutV [NDUT];

  assign doutV[0] = dout0;
  assign doutV[1] = {4'b0, dout1};
  assign doutV[2] = {4'b0, dout2};
  assign doutV[3] = dout3;
  assign doutV[4] = dout4;

  int total = 0;
  int bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];

  logic [11:0] lastDout [NDUT];
  logic        lastOvf  [NDUT];
  int          outCount [NDUT];
  logic        prevStall [NDUT];
  logic [11:0] prevDout  [NDUT];
  logic        prevOvf   [NDUT];

  vec_t vecs [8];

  always #5 clk = ~clk;

  myproject_mul_pipe #(.ID(0), .NUM_STAGE(2), .din0_WIDTH(3), .din1_WIDTH(9), .dout_WIDTH(12),
                       .DIN0_SIGNED(0), .DIN1_SIGNED(1), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_ready(inReady[0]),
    .din0(din0), .din1(din1), .out_valid(outValid[0]), .out_ready(outReady),
    .dout(dout0), .ovf(ovfV[0]), .busy(busyV[0]));

  myproject_mul_pipe #(.ID(1), .NUM_STAGE(2), .din0_WIDTH(3), .din1_WIDTH(9), .dout_WIDTH(8),
                       .DIN0_SIGNED(0), .DIN1_SIGNED(0), .SATURATE(0)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_ready(inReady[1]),
    .din0(din0), .din1(din1), .out_valid(outValid[1]), .out_ready(outReady),
    .dout(dout1), .ovf(ovfV[1]), .busy(busyV[1]));

  myproject_mul_pipe #(.ID(2), .NUM_STAGE(2), .din0_WIDTH(3), .din1_WIDTH(9), .dout_WIDTH(8),
                       .DIN0_SIGNED(0), .DIN1_SIGNED(0), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_ready(inReady[2]),
    .din0(din0), .din1(din1), .out_valid(outValid[2]), .out_ready(outReady),
    .dout(dout2), .ovf(ovfV[2]), .busy(busyV[2]));

  myproject_mul_pipe #(.ID(3), .NUM_STAGE(1), .din0_WIDTH(3), .din1_WIDTH(9), .dout_WIDTH(12),
                       .DIN0_SIGNED(0), .DIN1_SIGNED(1), .SATURATE(0)) dut3 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_ready(inReady[3]),
    .din0(din0), .din1(din1), .out_valid(outValid[3]), .out_ready(outReady),
    .dout(dout3), .ovf(ovfV[3]), .busy(busyV[3]));

  myproject_mul_pipe #(.ID(4), .NUM_STAGE(8), .din0_WIDTH(3), .din1_WIDTH(9), .dout_WIDTH(12),
                       .DIN0_SIGNED(0), .DIN1_SIGNED(1), .SATURATE(0)) dut4 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(inValid), .in_ready(inReady[4]),
    .din0(din0), .din1(din1), .out_valid(outValid[4]), .out_ready(outReady),
    .dout(dout4), .ovf(ovfV[4]), .busy(busyV[4]));

  // Range-based reference: all configurations treat din0 as unsigned.
  function automatic exp_t modelBeat(input int k, input logic [2:0] a, input logic [8:0] b);
    longint pa, pb, p, mn, mx, msk, v;
    logic o;
    exp_t e;
    pa = longint'(a);
    pb = longint'(b);
    if (CFG_D1S[k] != 0 && b[8]) pb = pb - 512;
    p = pa * pb;
    msk = (longint'(1) << CFG_DW[k]) - 1;
    if (CFG_D1S[k] != 0) begin
      mx = (longint'(1) << (CFG_DW[k] - 1)) - 1;
      mn = -mx - 1;
    end else begin
      mx = msk;
      mn = 0;
    end
    o = (p > mx) || (p < mn);
    v = p;
    if (CFG_SAT[k] != 0 && o) v = (p > mx) ? mx : mn;
    e.dout = 12'(v & msk);
    e.ovf  = o;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int qSize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic pushExp(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic popExp(input int k, output exp_t e, output bit ok);
    e = '0;
    ok = (qSize(k) != 0);
    if (ok) begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        2: e = q2.pop_front();
        3: e = q3.pop_front();
        default: e = q4.pop_front();
      endcase
    end
  endtask

  // Handshakes are evaluated at the falling edge, where they predict the
  // transfers of the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (reset) begin
      q0.delete(); q1.delete(); q2.delete(); q3.delete(); q4.delete();
      for (int k = 0; k < NDUT; k++) prevStall[k] = 1'b0;
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (prevStall[k]) begin
          checkOutput($sformatf("stall valid dut%0d", k), outValid[k], 1);
          checkOutput($sformatf("stall dout dut%0d", k), doutV[k], prevDout[k]);
          checkOutput($sformatf("stall ovf dut%0d", k), ovfV[k], prevOvf[k]);
        end
        if (inValid && inReady[k]) pushExp(k, modelBeat(k, din0, din1));
        if (outValid[k]) begin
          lastDout[k] = doutV[k];
          lastOvf[k]  = ovfV[k];
          outCount[k] = outCount[k] + 1;
        end
        if (outValid[k] && outReady && ce) begin
          popExp(k, e, ok);
          checkOutput($sformatf("sb beat expected dut%0d", k), ok, 1);
          if (ok) begin
            checkOutput($sformatf("sb dout dut%0d", k), doutV[k], e.dout);
            checkOutput($sformatf("sb ovf dut%0d", k), ovfV[k], e.ovf);
          end
        end
        prevStall[k] = outValid[k] && !outReady;
        prevDout[k]  = doutV[k];
        prevOvf[k]   = ovfV[k];
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] d0, input logic [8:0] d1);
    @(posedge clk); #1;
    din0 = d0;
    din1 = d1;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic measureLatency(input logic [2:0] d0, input logic [8:0] d1);
    int lat [NDUT];
    for (int k = 0; k < NDUT; k++) lat[k] = 0;
    @(posedge clk); #1;
    din0 = d0;
    din1 = d1;
    inValid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      inValid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) if (lat[k] == 0 && outValid[k]) lat[k] = c;
    end
    for (int k = 0; k < NDUT; k++)
      checkOutput($sformatf("latency dut%0d", k), lat[k], CFG_NS[k]);
  endtask

  task automatic drainAndCheck(input string tag);
    inValid = 1'b0;
    outReady = 1'b1;
    repeat (15) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("%s queue empty dut%0d", tag, k), qSize(k), 0);
      checkOutput($sformatf("%s busy idle dut%0d", tag, k), busyV[k], 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int sent;
    int cyc;
    int cnt [NDUT];
    int first [NDUT];
    int last [NDUT];
    logic        snapValid [NDUT];
    logic [11:0] snapDout  [NDUT];
    logic        snapBusy  [NDUT];
    int before0;

    for (int k = 0; k < NDUT; k++) begin
      outCount[k] = 0; lastDout[k] = '0; lastOvf[k] = 1'b0;
      prevStall[k] = 1'b0; prevDout[k] = '0; prevOvf[k] = 1'b0;
    end

    vecs[0] = '{3'd7, 9'h100, 12'h900, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[1] = '{3'd7, 9'h0FF, 12'h6F9, 8'hF9, 1'b1, 8'hFF, 1'b1};
    vecs[2] = '{3'd0, 9'h1FF, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{3'd3, 9'h055, 12'h0FF, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{3'd1, 9'h1FF, 12'hFFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{3'd2, 9'h080, 12'h100, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{3'd5, 9'h033, 12'h0FF, 8'hFF, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{3'd6, 9'h1F0, 12'hFA0, 8'hA0, 1'b1, 8'hFF, 1'b1};

    // Reset state
    #1 reset = 1'b1;
    ce = 1'b1;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("reset out_valid dut%0d", k), outValid[k], 0);
      checkOutput($sformatf("reset busy dut%0d", k), busyV[k], 0);
      checkOutput($sformatf("reset in_ready dut%0d", k), inReady[k], 0);
      checkOutput($sformatf("reset dout dut%0d", k), doutV[k], 0);
      checkOutput($sformatf("reset ovf dut%0d", k), ovfV[k], 0);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++)
      checkOutput($sformatf("idle in_ready dut%0d", k), inReady[k], 1);

    // Latency of a single beat, then the vector table
    measureLatency(3'd7, 9'h100);
    checkOutput("first beat dout dut0", lastDout[0], 12'h900);
    checkOutput("first beat ovf dut0", lastOvf[0], 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].d0, vecs[i].d1);
      repeat (10) @(negedge clk);
      checkOutput($sformatf("vec%0d dout dut0", i), lastDout[0], vecs[i].exp12);
      checkOutput($sformatf("vec%0d ovf dut0", i), lastOvf[0], 0);
      checkOutput($sformatf("vec%0d dout dut1", i), lastDout[1], {4'b0, vecs[i].exp8w});
      checkOutput($sformatf("vec%0d ovf dut1", i), lastOvf[1], vecs[i].ovf8w);
      checkOutput($sformatf("vec%0d dout dut2", i), lastDout[2], {4'b0, vecs[i].exp8s});
      checkOutput($sformatf("vec%0d ovf dut2", i), lastOvf[2], vecs[i].ovf8s);
      checkOutput($sformatf("vec%0d dout dut3", i), lastDout[3], vecs[i].exp12);
      checkOutput($sformatf("vec%0d dout dut4", i), lastDout[4], vecs[i].exp12);
    end

    // Back-to-back beats: one per cycle in, contiguous run out
    for (int k = 0; k < NDUT; k++) begin cnt[k] = 0; first[k] = -1; last[k] = -1; end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      inValid = (c < 8);
      din0 = 3'($urandom);
      din1 = 9'($urandom);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (c < 8) checkOutput($sformatf("b2b in_ready dut%0d", k), inReady[k], 1);
        if (outValid[k]) begin
          cnt[k]++;
          if (first[k] < 0) first[k] = c;
          last[k] = c;
        end
      end
    end
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("b2b count dut%0d", k), cnt[k], 8);
      checkOutput($sformatf("b2b span dut%0d", k), last[k] - first[k], 7);
      checkOutput($sformatf("b2b first dut%0d", k), first[k], CFG_NS[k]);
    end
    drainAndCheck("b2b");

    // Random backpressure stream of 16 beats accepted by dut0
    sent = 0;
    cyc = 0;
    while (sent < 16 && cyc < 400) begin
      @(posedge clk); #1;
      if (!inValid || inReady[0] || cyc == 0) begin
        din0 = 3'($urandom);
        din1 = 9'($urandom);
      end
      inValid = 1'b1;
      outReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (inValid && inReady[0]) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    checkOutput("stream beats sent", sent, 16);
    drainAndCheck("stream");

    // Clock enable held low for 5 cycles mid-stream
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      inValid = 1'b1;
      din0 = 3'($urandom);
      din1 = 9'($urandom);
    end
    @(posedge clk); #1;
    ce = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      snapValid[k] = outValid[k];
      snapDout[k]  = doutV[k];
      snapBusy[k]  = busyV[k];
    end
    checkOutput("ce low out_valid held dut0", snapValid[0], 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      din0 = 3'($urandom);
      din1 = 9'($urandom);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        checkOutput($sformatf("ce low valid dut%0d", k), outValid[k], snapValid[k]);
        checkOutput($sformatf("ce low dout dut%0d", k), doutV[k], snapDout[k]);
        checkOutput($sformatf("ce low busy dut%0d", k), busyV[k], snapBusy[k]);
        checkOutput($sformatf("ce low in_ready dut%0d", k), inReady[k], 0);
      end
    end
    @(posedge clk); #1;
    ce = 1'b1;
    drainAndCheck("ce");

    // Asynchronous reset with two beats in flight
    @(posedge clk); #1;
    inValid = 1'b1;
    din0 = 3'd3;
    din1 = 9'h011;
    @(posedge clk); #1;
    din0 = 3'd5;
    din1 = 9'h1EE;
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("pre-reset busy dut0", busyV[0], 1);
    checkOutput("pre-reset out_valid dut0", outValid[0], 1);
    #1 reset = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checkOutput($sformatf("async reset out_valid dut%0d", k), outValid[k], 0);
      checkOutput($sformatf("async reset busy dut%0d", k), busyV[k], 0);
      checkOutput($sformatf("async reset in_ready dut%0d", k), inReady[k], 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    before0 = outCount[0];
    repeat (12) @(negedge clk);
    checkOutput("no stale beat dut0", outCount[0] - before0, 0);
    for (int k = 0; k < NDUT; k++)
      checkOutput($sformatf("post-reset busy dut%0d", k), busyV[k], 0);
    measureLatency(3'd6, 9'h1F0);
    checkOutput("post-reset dout dut0", lastDout[0], 12'hFA0);
    drainAndCheck("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/myproject_mul_pipe.md
MYPROJECT_MUL_PIPE -- requirements
Module: myproject_mul_pipe

Interface
REQ-001 SHALL have parameter ID, default 1, instance tag with no functional effect.
REQ-002 SHALL have parameter NUM_STAGE, default 2, register stages from input to output; legal range 1..8.
REQ-003 SHALL have parameter din0_WIDTH, default 3, operand 0 width; legal range 1..32.
REQ-004 SHALL have parameter din1_WIDTH, default 9, operand 1 width; legal range 1..32.
REQ-005 SHALL have parameter dout_WIDTH, default 12, result width; legal range 1..64.
REQ-006 SHALL have parameter DIN0_SIGNED, default 0, where 1 means din0 is two's complement.
REQ-007 SHALL have parameter DIN1_SIGNED, default 1, where 1 means din1 is two's complement.
REQ-008 SHALL have parameter SATURATE, default 0, where 0 means wrap (keep LSBs) and 1 means clamp to the dout range.
REQ-009 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1 bit, reset that is asynchronous and active-high.
REQ-011 SHALL have port ce, input, 1 bit, clock enable; when low, all state holds.
REQ-012 SHALL have port in_valid, input, 1 bit, operands present.
REQ-013 SHALL have port in_ready, output, 1 bit, operands accepted this cycle.
REQ-014 SHALL have port din0, input, din0_WIDTH bits, operand 0.
REQ-015 SHALL have port din1, input, din1_WIDTH bits, operand 1.
REQ-016 SHALL have port out_valid, output, 1 bit, result present.
REQ-017 SHALL have port out_ready, input, 1 bit, downstream accepts.
REQ-018 SHALL have port dout, output, dout_WIDTH bits, result.
REQ-019 SHALL have port ovf, output, 1 bit, high when the dout beat lost information through wrap or clamp.
REQ-020 SHALL have port busy, output, 1 bit, high when any stage holds a valid beat.

Function
REQ-021 SHALL form the full product at width P = din0_WIDTH+din1_WIDTH, extending each operand per its SIGNED parameter; the result is signed if either operand is signed.
REQ-022 SHALL define advance = ce AND (NOT out_valid OR out_ready); all stages, data and valid, shift only when advance is 1.
REQ-023 SHALL drive in_ready = advance; a beat transfers when in_valid AND in_ready.
REQ-024 SHALL give a latency of exactly NUM_STAGE advancing cycles from input transfer to out_valid.
REQ-025 SHALL sustain a throughput of one beat per cycle while out_ready=1 and ce=1.
REQ-026 SHALL hold dout, ovf and out_valid stable while out_valid=1 and out_ready=0 (stall); no beat is dropped or duplicated.
REQ-027 SHALL insert a bubble (valid=0) at stage 1 when a stage advances with no input transfer.
REQ-028 SHALL, in wrap mode, output dout = product[dout_WIDTH-1:0], with ovf=1 iff the sign- or zero-extension of dout differs from the product.
REQ-029 SHALL, in saturate mode, clamp out-of-range products to max/min of dout's signedness, with ovf=1 when a clamp occurs.
REQ-030 SHALL output a zero- or sign-extended product with ovf=0 when dout_WIDTH >= P.
REQ-031 SHALL compute ovf and clamp in the final stage, and place multiply registers in the earlier stages. With NUM_STAGE=1, both are computed in one stage.
REQ-032 SHALL, when ce falls while out_valid=1, keep out_valid asserted and perform no transfer.
REQ-033 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-034 SHALL, on reset assertion, immediately clear all valid bits, out_valid, ovf and busy, regardless of clk or ce.
REQ-035 SHALL reset dout to 0; data-path registers other than valids need no reset.
REQ-036 SHALL discard in-flight beats on reset mid-operation; the first beat after deassertion emerges after NUM_STAGE advancing cycles.
REQ-037 SHALL keep in_ready low while reset is high.

Structure
REQ-038 SHALL place in a shared package the stage-count limit and a function computing full product width and saturation bounds.
REQ-039 SHALL use one sub-module, myproject_mul_pipe_sat, that implements the combinational wrap/clamp and ovf for the final stage.
REQ-040 SHALL not use a FIFO; backpressure uses the global stall per REQ-022.

Verification
REQ-041 SHALL test defaults with din0=7 and din1=-256 (0x100): dout=0x900 (-1792) and ovf=0, with out_valid exactly 2 cycles after transfer.
REQ-042 SHALL test dout_WIDTH=8 with both operands unsigned: 7*255=1785 gives dout=0xF9 and ovf=1 in wrap mode, and dout=0xFF and ovf=1 in saturate mode.
REQ-043 SHALL test a stream of 16 beats with out_ready toggling randomly: outputs match in order with no loss or duplication, and dout is stable during stalls.
REQ-044 SHALL test ce held low for 5 cycles mid-stream: no state change and out_valid held; after resuming, results are correct.
REQ-045 SHALL test reset asserted asynchronously with 2 beats in flight: out_valid and busy go to 0 before the next clk edge, and no stale beat appears after release.
REQ-046 SHALL test NUM_STAGE=1 and NUM_STAGE=8 under back-to-back beats: latency is 1 and 8 cycles respectively, and throughput is 1 per cycle.
